ram_wr_ctrl: RTL

Write-side controller for the interleaver table RAM banks. It accepts a stream of table words over a valid/ready handshake and writes them to addresses 0..len-1 of one selected bank out of four. It then signals completion with a one-cycle done pulse. It sits between the table source (host/config path) and the registered-read RAM banks consumed by the RX turbo interleaver. An optional read-back pass re-reads the filled bank and flags corruption.

---
 rtl/ram_wr_pkg.sv | 23 ++
 rtl/ram_wr_ctrl_if.sv | 23 ++
 rtl/ram_wr_verify.sv | 113 +++++++++++
 rtl/ram_wr_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_wr_pkg.sv
// -----------------------------------------------------------------------------
// ram_wr_pkg
// Shared definitions for the interleaver table RAM write controller:
//   - default word/address widths and bank count
//   - FSM state encoding shared by the controller and anyone decoding it
// No ports (package).
// -----------------------------------------------------------------------------
package ram_wr_pkg;

  localparam int D_WIDTH_DEF = 16;  // table word width
  localparam int A_WIDTH_DEF = 10;  // bank address width (depth 2**A_WIDTH)
  localparam int N_BANK_DEF  = 4;   // number of RAM banks

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_GAP    = 3'd2,
    ST_VERIFY = 3'd3,
    ST_VWAIT  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/ram_wr_ctrl_if.sv
// -----------------------------------------------------------------------------
// ram_wr_ctrl_if
// Valid/ready stream carrying table words from the table source into the
// write controller.
//   s_valid : source word valid        (master -> slave)
//   s_data  : source word, D_WIDTH     (master -> slave)
//   s_ready : controller accepts word  (slave -> master)
// Modports: master = table source, slave = ram_wr_ctrl.
// -----------------------------------------------------------------------------
interface ram_wr_ctrl_if
  import ram_wr_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF
);

  logic               s_valid;
  logic [D_WIDTH-1:0] s_data;
  logic               s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/ram_wr_verify.sv
// -----------------------------------------------------------------------------
// ram_wr_verify
// Read-back helper for ram_wr_ctrl: sequences read addresses 0..len-1, sums
// the written words (wsum) and the read-back words (rsum) and flags a
// mismatch on request.
// Ports:
//   clk, n_rst        : clock, asynchronous active-low reset
//   clr               : accepted start; clears sums, err and the sequencer
//   wr_fire, wr_data  : accepted source word, added to wsum
//   seq_go            : launch the read sequence (issues address 0 next cycle)
//   len               : number of addresses to read (already clamped)
//   rdata             : RAM read data, valid one cycle after ren
//   cmp               : final read-data cycle; register err = (wsum != rsum)
//   seq_last          : the read currently issued is the last one
//   ren, raddr        : registered read enable / address
//   err               : registered, sticky mismatch flag
// -----------------------------------------------------------------------------
module ram_wr_verify
  import ram_wr_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int A_WIDTH = A_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               clr,
  input  logic               wr_fire,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic               seq_go,
  input  logic [A_WIDTH:0]   len,
  input  logic [D_WIDTH-1:0] rdata,
  input  logic               cmp,
  output logic               seq_last,
  output logic               ren,
  output logic [A_WIDTH-1:0] raddr,
  output logic               err
);

  localparam logic [A_WIDTH:0] ONE = {{A_WIDTH{1'b0}}, 1'b1};

  logic               ren_q, ren_d;
  logic [A_WIDTH-1:0] raddr_q, raddr_d;
  logic [A_WIDTH:0]   vcnt_q, vcnt_d;      // addresses issued so far
  logic               rd_pend_q, rd_pend_d; // rdata carries a valid word this cycle
  logic [D_WIDTH-1:0] wsum_q, wsum_d;
  logic [D_WIDTH-1:0] rsum_q, rsum_d;
  logic               err_q, err_d;

  assign seq_last = ren_q && (vcnt_q == len);

  always_comb begin
    ren_d     = ren_q;
    raddr_d   = raddr_q;
    vcnt_d    = vcnt_q;
    rd_pend_d = ren_q;
    wsum_d    = wsum_q;
    rsum_d    = rsum_q;
    err_d     = err_q;

    if (wr_fire) wsum_d = wsum_q + wr_data;
    if (rd_pend_q) rsum_d = rsum_q + rdata;

    if (seq_go) begin
      ren_d   = 1'b1;
      raddr_d = '0;
      vcnt_d  = ONE;
    end else if (ren_q) begin
      if (seq_last) begin
        ren_d = 1'b0;
      end else begin
        raddr_d = vcnt_q[A_WIDTH-1:0];
        vcnt_d  = vcnt_q + ONE;
      end
    end

    // The last read word is still on rdata during cmp, so fold it in here
    // rather than waiting for rsum_q to catch up.
    if (cmp) err_d = (wsum_q != (rsum_q + rdata));

    if (clr) begin
      ren_d     = 1'b0;
      rd_pend_d = 1'b0;
      wsum_d    = '0;
      rsum_d    = '0;
      err_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ren_q     <= 1'b0;
      raddr_q   <= '0;
      vcnt_q    <= '0;
      rd_pend_q <= 1'b0;
      wsum_q    <= '0;
      rsum_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      ren_q     <= ren_d;
      raddr_q   <= raddr_d;
      vcnt_q    <= vcnt_d;
      rd_pend_q <= rd_pend_d;
      wsum_q    <= wsum_d;
      rsum_q    <= rsum_d;
      err_q     <= err_d;
    end
  end

  assign ren   = ren_q;
  assign raddr = raddr_q;
  assign err   = err_q;

endmodule

// File: rtl/ram_wr_ctrl.sv
// -----------------------------------------------------------------------------
// ram_wr_ctrl
// Write-side controller for the interleaver table RAM banks. Accepts len
// table words over a valid/ready stream and writes them to addresses
// 0..len-1 of the selected bank, then pulses done for one cycle.
// Optional read-back pass (macro RAM_WR_READBACK_EN) re-reads the bank and
// sets err when the read-back sum differs from the written sum.
// Ports:
//   clk, n_rst   : clock, asynchronous active-low reset
//   start        : fill request, sampled only in IDLE
//   bank, len    : target bank / word count, latched on accepted start
//   s_if (slave) : s_valid / s_data / s_ready source stream
//   wen          : one-hot bank write enable (N_BANK wide)
//   waddr, wdata : write address / data
//   ren, raddr   : read-back enable / address (0 without read-back)
//   rdata        : read-back data, valid one cycle after ren
//   busy         : high in every state except IDLE
//   done         : one-cycle completion pulse
//   err          : read-back mismatch, sticky until the next accepted start
// All outputs are registered.
// -----------------------------------------------------------------------------
module ram_wr_ctrl
  import ram_wr_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int N_BANK  = N_BANK_DEF
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic [1:0]         bank,
  input  logic [A_WIDTH:0]   len,
  ram_wr_ctrl_if.slave       s_if,
  output logic [N_BANK-1:0]  wen,
  output logic [A_WIDTH-1:0] waddr,
  output logic [D_WIDTH-1:0] wdata,
  output logic               ren,
  output logic [A_WIDTH-1:0] raddr,
  input  logic [D_WIDTH-1:0] rdata,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [A_WIDTH:0]  DEPTH   = {1'b1, {A_WIDTH{1'b0}}};
  localparam logic [A_WIDTH:0]  ONE     = {{A_WIDTH{1'b0}}, 1'b1};
  localparam logic [N_BANK-1:0] WEN_ONE = {{(N_BANK-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [1:0]         bank_q, bank_d;
  logic [A_WIDTH:0]   len_q, len_d;
  logic [A_WIDTH:0]   count_q, count_d;   // one bit wider so len == DEPTH fits
  logic               s_ready_q, s_ready_d;
  logic [N_BANK-1:0]  wen_q, wen_d;
  logic [A_WIDTH-1:0] waddr_q, waddr_d;
  logic [D_WIDTH-1:0] wdata_q, wdata_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [A_WIDTH:0]   len_clamp;
  logic               wr_fire;

  assign len_clamp = (len > DEPTH) ? DEPTH : len;
  assign wr_fire   = (state_q == ST_FILL) && s_if.s_valid && s_ready_q;

`ifdef RAM_WR_READBACK_EN
  logic seq_last;
  logic clr;
  logic seq_go;
  logic cmp;

  assign clr    = (state_q == ST_IDLE) && start;
  assign seq_go = (state_q == ST_GAP);
  assign cmp    = (state_q == ST_VWAIT);

  ram_wr_verify #(
    .D_WIDTH (D_WIDTH),
    .A_WIDTH (A_WIDTH)
  ) u_verify (
    .clk      (clk),
    .n_rst    (n_rst),
    .clr      (clr),
    .wr_fire  (wr_fire),
    .wr_data  (s_if.s_data),
    .seq_go   (seq_go),
    .len      (len_q),
    .rdata    (rdata),
    .cmp      (cmp),
    .seq_last (seq_last),
    .ren      (ren),
    .raddr    (raddr),
    .err      (err)
  );
`else
  logic unused_rdata;

  assign unused_rdata = ^rdata;
  assign ren          = 1'b0;
  assign raddr        = '0;
  assign err          = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    len_d     = len_q;
    count_d   = count_q;
    s_ready_d = 1'b0;
    wen_d     = '0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bank_d  = bank;
          len_d   = len_clamp;
          count_d = '0;
          busy_d  = 1'b1;
          if (len_clamp == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = ST_FILL;
            s_ready_d = 1'b1;
          end
        end
      end

      ST_FILL: begin
        s_ready_d = 1'b1;
        if (wr_fire) begin
          wen_d   = WEN_ONE << bank_q;
          waddr_d = count_q[A_WIDTH-1:0];
          wdata_d = s_if.s_data;
          count_d = count_q + ONE;
          if (count_q == len_q - ONE) begin
            // Drop ready together with the state change so no extra word
            // can be accepted in the cycle after the last one.
            s_ready_d = 1'b0;
`ifdef RAM_WR_READBACK_EN
            state_d   = ST_GAP;
`else
            state_d   = ST_DONE;
            done_d    = 1'b1;
`endif
          end
        end
      end

`ifdef RAM_WR_READBACK_EN
      // The last write lands during GAP; the sequencer issues address 0
      // on the following cycle.
      ST_GAP: state_d = ST_VERIFY;

      ST_VERIFY: begin
        if (seq_last) state_d = ST_VWAIT;
      end

      ST_VWAIT: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
`endif

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= ST_IDLE;
      bank_q    <= '0;
      len_q     <= '0;
      count_q   <= '0;
      s_ready_q <= 1'b0;
      wen_q     <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bank_q    <= bank_d;
      len_q     <= len_d;
      count_q   <= count_d;
      s_ready_q <= s_ready_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign s_if.s_ready = s_ready_q;
  assign wen          = wen_q;
  assign waddr        = waddr_q;
  assign wdata        = wdata_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
